// File: rtl/jtsdram_pkg.sv
// rtl/jtsdram_pkg.sv - shared seed, fill/check state encoding and address-derived test pattern
package jtsdram_pkg;

  localparam logic [7:0] JTSDRAM_SEED = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_WR,
    ST_GAP,
    ST_RD,
    ST_RIDLE,
    ST_NEXTB,
    ST_DONE
  } fill_state_t;

  function automatic logic [15:0] pattern(input logic [1:0]  ba,
                                          input logic [21:0] addr,
                                          input logic [7:0]  seed);
    return addr[15:0] ^ {addr[21:16], ba, seed};
  endfunction

endpackage

// File: rtl/jtsdram_fill_tout.sv
// rtl/jtsdram_fill_tout.sv - resettable wait-cycle counter; expired marks the TOUT-th cycle of a wait
module jtsdram_fill_tout #(
  parameter int TOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (start)   cnt <= cnt + CW'(1);
  end

  assign expired = start && (cnt == CW'(TOUT - 1));

endmodule

// File: rtl/jtsdram_fill.sv
// rtl/jtsdram_fill.sv - fills SDRAM banks with a pattern before the checker; JTSDRAM_FILL_VERIFY_EN adds read-back
module jtsdram_fill
  import jtsdram_pkg::*;
#(
  parameter int          AW    = 22,
  parameter int          BANKS = 4,
  parameter logic [7:0]  SEED  = JTSDRAM_SEED,
  parameter int          TOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  output logic        dwnld_busy,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  output logic        prog_rd,
  input  logic        prog_rdy,
  input  logic        prog_ack,
  input  logic [15:0] data_read,
  output logic        fill_err
);

  fill_state_t   state, state_nxt;
  logic [AW-1:0] addr;
  logic [2:0]    bank;  // one bit wider than prog_ba so bank==BANKS is reachable
  logic          last, waiting, adv, tout_exp;
  logic          unused_in;

  assign last = &addr;
  assign unused_in = ^{prog_ack, data_read};

`ifdef JTSDRAM_FILL_VERIFY_EN
  assign waiting = (state == ST_WR) || (state == ST_RD);
  assign adv     = (state == ST_RIDLE);
  assign prog_rd = (state == ST_RD);
`else
  assign waiting = (state == ST_WR);
  assign adv     = (state == ST_GAP);
  assign prog_rd = 1'b0;
`endif

  assign prog_we    = (state == ST_WR);
  assign prog_mask  = 2'b00;
  assign dwnld_busy = (state != ST_DONE);

  jtsdram_fill_tout #(.TOUT(TOUT)) u_tout (
    .clk     (clk),
    .rst     (rst),
    .start   (waiting),
    .clear   (!waiting),
    .expired (tout_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!downloading) state_nxt = ST_SET;
      ST_SET:   state_nxt = ST_WR;
      ST_WR:    if (prog_rdy || tout_exp) state_nxt = ST_GAP;
`ifdef JTSDRAM_FILL_VERIFY_EN
      ST_GAP:   state_nxt = ST_RD;
      ST_RD:    if (prog_rdy || tout_exp) state_nxt = ST_RIDLE;
      ST_RIDLE: state_nxt = last ? ST_NEXTB : ST_SET;
`else
      ST_GAP:   state_nxt = last ? ST_NEXTB : ST_SET;
`endif
      ST_NEXTB: state_nxt = (bank == 3'(BANKS)) ? ST_DONE : ST_SET;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      bank      <= '0;
      prog_addr <= '0;
      prog_ba   <= '0;
      prog_data <= '0;
      fill_err  <= 1'b0;
    end else begin
      if (state == ST_SET) begin
        prog_addr <= 22'(addr);
        prog_ba   <= bank[1:0];
        prog_data <= pattern(bank[1:0], 22'(addr), SEED);
      end
      // rdy in the expiry cycle still counts as success
      if (state == ST_WR && tout_exp && !prog_rdy) fill_err <= 1'b1;
`ifdef JTSDRAM_FILL_VERIFY_EN
      if (state == ST_RD && ((prog_rdy && data_read != prog_data) || (tout_exp && !prog_rdy)))
        fill_err <= 1'b1;
`endif
      if (adv) begin
        addr <= addr + AW'(1);
        if (last) bank <= bank + 3'd1;
      end
    end
  end

endmodule
